ram_port_sequencer: RTL and testbench

- Command front-end for one port of the dual-port RAM. Buffers read/write requests from a producer in a small FIFO and serialises them into single-cycle RAM strobes.
- Returns read data over a valid/ready response channel, covering the RAM's read latency.
- Screens out-of-range addresses before they reach the RAM.
- One instance per RAM port; each instance runs in that port's clock domain.

---
 rtl/ram_seq_pkg.sv | 22 ++
 rtl/seq_cmd_fifo.sv | 50 +++++
 rtl/ram_port_sequencer.sv | 165 ++++++++++++++++
 tb/tb_ram_port_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_seq_pkg.sv
// Shared types for the RAM port sequencer: FSM states, the buffered command
// record and the error counter width.
package ram_seq_pkg;

  localparam int unsigned ERR_CNT_W  = 8;
  localparam int unsigned CMD_ADDR_W = 10;
  localparam int unsigned CMD_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } seq_state_t;

  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through read data and an
// occupancy count. Push while full and pop while empty are ignored.
module seq_cmd_fifo
  import ram_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  cmd_t                       wr_data,
  input  logic                       pop,
  output cmd_t                       rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ram_port_sequencer.sv
// Per-port RAM command front-end: buffers commands, issues one-cycle RAM
// strobes, returns read data. Define RAM_SEQ_WRITE_ACK_EN to acknowledge writes.
module ram_port_sequencer
  import ram_seq_pkg::*;
#(
  parameter int unsigned ADDR_W     = CMD_ADDR_W,
  parameter int unsigned DATA_W     = CMD_DATA_W,
  parameter int unsigned MEM_DEPTH  = 512,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 ram_wren,
  output logic                 ram_rden,
  output logic [ADDR_W-1:0]    ram_address,
  output logic [DATA_W-1:0]    ram_data,
  input  logic [DATA_W-1:0]    ram_q,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

`ifdef RAM_SEQ_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_t       state;
  seq_state_t       state_next;
  cmd_t             cmd_in;
  cmd_t             head;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] cnt_next;
  logic             head_in_range;
  logic             cur_we;
  logic [2:0]       lat_cnt;

  assign cmd_in.we    = cmd_we;
  assign cmd_in.addr  = cmd_addr;
  assign cmd_in.wdata = cmd_wdata;

  assign push     = cmd_valid && cmd_ready && !fifo_full;
  assign cnt_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

  seq_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (cmd_in),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Ready is registered from the post-update count, so a pop while full
  // cannot make room for a push in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) cmd_ready <= 1'b0;
    else     cmd_ready <= (cnt_next != CNT_W'(FIFO_DEPTH));
  end

  assign head_in_range = (32'(head.addr) < MEM_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_in_range)          state_next = ISSUE;
          else if (!head.we || WR_ACK) state_next = RESP;
        end
      end
      ISSUE: begin
        if (!cur_we)     state_next = WAIT;
        else if (WR_ACK) state_next = RESP;
        else             state_next = IDLE;
      end
      WAIT: begin
        if (lat_cnt == 3'd1) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_we      <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      err_count   <= '0;
      lat_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cur_we <= head.we;
            if (head_in_range) begin
              ram_address <= head.addr;
              if (head.we) ram_data <= head.wdata;
            end else begin
              if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
              if (!head.we || WR_ACK) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          lat_cnt <= 3'(RD_LATENCY);
          if (cur_we && WR_ACK) begin
            rsp_rdata <= ram_data;
            rsp_err   <= 1'b0;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            rsp_rdata <= ram_q;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_wren  = (state == ISSUE) && cur_we;
  assign ram_rden  = (state == ISSUE) && !cur_we;
  assign rsp_valid = (state == RESP);
  assign busy      = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_ram_port_sequencer.sv
// Directed self-checking bench for ram_port_sequencer with a queue-based
// reference model and a behavioural RAM with one cycle of read latency.
module tb_ram_port_sequencer;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;
  localparam int MEM_DEPTH  = 512;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LATENCY = 1;

`ifdef RAM_SEQ_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              ram_wren;
  logic              ram_rden;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;
  logic              busy;
  logic [7:0]        err_count;

  ram_port_sequencer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_DEPTH  (MEM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RD_LATENCY (RD_LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .ram_wren    (ram_wren),
    .ram_rden    (ram_rden),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_q       (ram_q),
    .busy        (busy),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: write on strobe, read data valid the cycle after rden.
  logic [DATA_W-1:0] ram_mem   [1024];
  logic [DATA_W-1:0] model_mem [1024];

  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    if (ram_rden) ram_q <= ram_mem[ram_address];
  end

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } strobe_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  strobe_t exp_strobes [$];
  rsp_t    exp_rsps    [$];
  int      model_err;
  int      n_checks;
  int      n_fail;
  int      rsp_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what every accepted command must eventually produce.
  function automatic void model_accept(input logic we, input logic [ADDR_W-1:0] addr,
                                       input logic [DATA_W-1:0] data);
    strobe_t s;
    rsp_t    r;
    if (int'(addr) < MEM_DEPTH) begin
      s.we = we; s.addr = addr; s.data = data;
      exp_strobes.push_back(s);
      if (we) begin
        model_mem[addr] = data;
        if (WR_ACK) begin
          r.data = data; r.err = 1'b0;
          exp_rsps.push_back(r);
        end
      end else begin
        r.data = model_mem[addr]; r.err = 1'b0;
        exp_rsps.push_back(r);
      end
    end else begin
      if (model_err < 255) model_err++;
      if (!we || WR_ACK) begin
        r.data = '0; r.err = 1'b1;
        exp_rsps.push_back(r);
      end
    end
  endfunction

  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              hold_err;
  strobe_t           cs;
  rsp_t              cr;

  always @(negedge clk) begin
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      check("strobe_exclusive", 32'(ram_wren && ram_rden), 32'd0);
      if (ram_wren || ram_rden) begin
        if (exp_strobes.size() == 0) begin
          check("strobe_unexpected", 32'({ram_wren, ram_rden}), 32'd0);
        end else begin
          cs = exp_strobes.pop_front();
          check("strobe_we", 32'(ram_wren), 32'(cs.we));
          check("strobe_addr", 32'(ram_address), 32'(cs.addr));
          if (cs.we) check("strobe_data", 32'(ram_data), 32'(cs.data));
        end
      end
      if (hold_valid) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_data", 32'(rsp_rdata), 32'(hold_data));
        check("rsp_hold_err", 32'(rsp_err), 32'(hold_err));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsps.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          cr = exp_rsps.pop_front();
          check("rsp_data", 32'(rsp_rdata), 32'(cr.data));
          check("rsp_err", 32'(rsp_err), 32'(cr.err));
        end
        rsp_seen++;
      end
      hold_valid = rsp_valid && !rsp_ready;
      hold_data  = rsp_rdata;
      hold_err   = rsp_err;
      if (!busy && !rsp_valid) check("err_count_model", 32'(err_count), 32'(model_err));
      if (cmd_valid && cmd_ready) model_accept(cmd_we, cmd_addr, cmd_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    int t;
    cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || rsp_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(busy || rsp_valid), 32'd0);
    check("strobes_left", 32'(exp_strobes.size()), 32'd0);
    check("rsps_left", 32'(exp_rsps.size()), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_strobes.delete();
    exp_rsps.delete();
    model_err = 0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_ram_strobes", 32'({ram_wren, ram_rden}), 32'd0);
    check("rst_ram_address", 32'(ram_address), 32'd0);
    check("rst_ram_data", 32'(ram_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    check("rst_ready_rise", 32'(cmd_ready), 32'd1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    n_checks = 0; n_fail = 0; rsp_seen = 0; model_err = 0;
    hold_valid = 1'b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i]   = 8'(i * 3 + 1);
      model_mem[i] = 8'(i * 3 + 1);
    end
    tick();
    do_reset();

    // Write then read back, with cycle-exact strobe and response timing.
    send(1'b1, 10'd10, 8'h90);
    @(negedge clk); check("wr_c1_no_strobe", 32'(ram_wren), 32'd0);
    @(negedge clk); check("wr_c2_wren", 32'(ram_wren), 32'd1);
    check("wr_c2_addr", 32'(ram_address), 32'd10);
    check("wr_c2_data", 32'(ram_data), 32'h90);
    @(negedge clk); check("wr_c3_wren_low", 32'(ram_wren), 32'd0);
    wait_idle();
    send(1'b0, 10'd10, 8'h00);
    @(negedge clk); check("rd_c1_no_strobe", 32'(ram_rden), 32'd0);
    @(negedge clk); check("rd_c2_rden", 32'(ram_rden), 32'd1);
    check("rd_c2_addr", 32'(ram_address), 32'd10);
    @(negedge clk); check("rd_c3_no_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); check("rd_c4_valid", 32'(rsp_valid), 32'd1);
    check("rd_c4_data", 32'(rsp_rdata), 32'h90);
    check("rd_c4_err", 32'(rsp_err), 32'd0);
    wait_idle();

    // Out-of-range write and read.
    send(1'b1, 10'd512, 8'h10);
    wait_idle();
    check("oor_wr_err_count", 32'(err_count), 32'd1);
    send(1'b0, 10'd600, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check("oor_rd_valid", 32'(rsp_valid), 32'd1);
    check("oor_rd_err", 32'(rsp_err), 32'd1);
    check("oor_rd_data", 32'(rsp_rdata), 32'd0);
    check("oor_rd_err_count", 32'(err_count), 32'd2);
    check("oor_rd_no_rden", 32'(ram_rden), 32'd0);
    wait_idle();

    // Back-pressure: five reads with the consumer stalled.
    rsp_ready = 1'b0;
    base = rsp_seen;
    for (int i = 0; i < 5; i++) send(1'b0, 10'(50 + i), 8'h00);
    @(negedge clk);
    check("bp_ready_low", 32'(cmd_ready), 32'd0);
    check("bp_first_valid", 32'(rsp_valid), 32'd1);
    check("bp_first_data", 32'(rsp_rdata), 32'h97);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("bp_still_full", 32'(cmd_ready), 32'd0);
    tick();
    rsp_ready = 1'b1;
    wait_idle();
    check("bp_rsp_count", 32'(rsp_seen - base), 32'd5);

    // Reset while waiting on the RAM read latency.
    send(1'b0, 10'd20, 8'h00);
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(rsp_valid), 32'd0);
    end
    tick();
    send(1'b0, 10'd21, 8'h00);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("post_rst_rd_valid", 32'(rsp_valid), 32'd1);
    check("post_rst_rd_data", 32'(rsp_rdata), 32'h40);
    wait_idle();

    // Error counter saturation.
    for (int i = 0; i < 260; i++) send(1'b1, 10'(700 + (i % 100)), 8'(i));
    wait_idle();
    check("err_saturated", 32'(err_count), 32'd255);

    // Write acknowledgement behaviour.
    send(1'b1, 10'd30, 8'hAA);
    @(negedge clk);
    @(negedge clk); check("ack_wr_wren", 32'(ram_wren), 32'd1);
    @(negedge clk);
`ifdef RAM_SEQ_WRITE_ACK_EN
    check("ack_rsp_valid", 32'(rsp_valid), 32'd1);
    check("ack_rsp_data", 32'(rsp_rdata), 32'hAA);
    check("ack_rsp_err", 32'(rsp_err), 32'd0);
`else
    check("noack_rsp_valid", 32'(rsp_valid), 32'd0);
`endif
    wait_idle();
    send(1'b0, 10'd30, 8'h00);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("ack_readback", 32'(rsp_rdata), 32'hAA);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
